// File: rtl/aespim_enc_sequencer.sv
// Command initiator for aespim_accelerator: expands one 128-bit plaintext request into
// the LD/ENCI/ENCM/ENCF/ST op stream and collects the 128-bit ciphertext.
module aespim_enc_sequencer #(
    parameter int unsigned NR         = 10,
    parameter int unsigned ST_LATENCY = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] pt_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] ct_o,
    output logic [3:0]   rk_idx_o,
    output logic [1:0]   rk_word_o,
    input  logic [31:0]  rk_data_i,
    output logic         acc_start_o,
    output logic [4:0]   acc_op_code_o,
    output logic [31:0]  acc_data_o,
    input  logic [31:0]  acc_data_i,
    output logic         busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ENCI  = 3'd2;
    localparam logic [2:0] S_ENCM  = 3'd3;
    localparam logic [2:0] S_ENCF  = 3'd4;
    localparam logic [2:0] S_STORE = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;
    localparam logic [2:0] S_RESP  = 3'd7;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ENCF = 5'b00110;

    localparam logic [3:0] RK_LAST = 4'(NR);
    localparam logic [3:0] R_LAST  = 4'(NR - 1);

    logic [2:0]   state_q, state_d;
    logic [1:0]   w_q, w_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] ct_q, ct_d;

    // Capture pipeline: one slot per cycle of ST latency, tagged with the word index.
    logic [ST_LATENCY-1:0]      cap_vld_q;
    logic [ST_LATENCY-1:0][1:0] cap_idx_q;
    logic                       cap_hit;
    logic [1:0]                 cap_idx;

    assign cap_hit = cap_vld_q[ST_LATENCY-1];
    assign cap_idx = cap_idx_q[ST_LATENCY-1];

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        pt_d    = pt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    pt_d    = pt_i;
                    w_d     = '0;
                    r_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                w_d = w_q + 2'd1;
                if (w_q == 2'd3) state_d = S_ENCI;
            end
            S_ENCI: begin
                w_d = w_q + 2'd1;
                if (w_q == 2'd3) begin
                    r_d     = 4'd1;
                    state_d = S_ENCM;
                end
            end
            S_ENCM: begin
                w_d = w_q + 2'd1;
                if (w_q == 2'd3) begin
                    if (r_q == R_LAST) state_d = S_ENCF;
                    else               r_d     = r_q + 4'd1;
                end
            end
            S_ENCF: begin
                w_d = w_q + 2'd1;
                if (w_q == 2'd3) state_d = S_STORE;
            end
            S_STORE: begin
                w_d = w_q + 2'd1;
                if (w_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cap_hit && cap_idx == 2'd3) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_start_o   = 1'b0;
        acc_op_code_o = '0;
        acc_data_o    = '0;
        rk_idx_o      = '0;
        rk_word_o     = '0;
        case (state_q)
            S_LOAD: begin
                acc_start_o   = 1'b1;
                acc_op_code_o = OP_LD;
                acc_data_o    = pt_q[{~w_q, 5'b0} +: 32];
            end
            S_ENCI: begin
                acc_start_o   = 1'b1;
                acc_op_code_o = {w_q, 3'b100};
                rk_word_o     = w_q;
                acc_data_o    = rk_data_i;
            end
            S_ENCM: begin
                acc_start_o   = 1'b1;
                acc_op_code_o = {w_q, 3'b101};
                rk_idx_o      = r_q;
                rk_word_o     = w_q;
                acc_data_o    = rk_data_i;
            end
            S_ENCF: begin
                acc_start_o   = 1'b1;
                acc_op_code_o = OP_ENCF;
                rk_idx_o      = RK_LAST;
                rk_word_o     = w_q;
                acc_data_o    = rk_data_i;
            end
            S_STORE: begin
                acc_start_o   = 1'b1;
                acc_op_code_o = OP_ST;
            end
            default: ;
        endcase
    end

    always_comb begin
        ct_d = ct_q;
        if (cap_hit) ct_d[{~cap_idx, 5'b0} +: 32] = acc_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            r_q     <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            r_q     <= r_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_vld_q <= '0;
            cap_idx_q <= '0;
        end else begin
            cap_vld_q[0] <= (state_q == S_STORE);
            cap_idx_q[0] <= w_q;
            for (int unsigned i = 1; i < ST_LATENCY; i++) begin
                cap_vld_q[i] <= cap_vld_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign ct_o        = ct_q;

endmodule

// File: tb/tb_aespim_enc_sequencer.sv
// Bench for aespim_enc_sequencer: two instances (ST latency 1 and 3) driving a behavioural
// AES accelerator model and key ROM, checked against a plain AES-128 reference.
module tb_aespim_enc_sequencer;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  idx;
        logic [1:0]  wd;
        logic [31:0] d;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [127:0] pt_drv;
    logic [1:0] req_v, rsp_r, req_rdy, rsp_v, start, busy;
    logic [1:0][127:0] ct;
    logic [1:0][3:0]   rk_idx;
    logic [1:0][1:0]   rk_word;
    logic [1:0][4:0]   op;
    logic [1:0][31:0]  acc_do, acc_di, rk_d;

    logic [127:0] rom [16];
    logic [7:0]   sbox [256];
    int n_cmp, n_fail, cyc;
    op_t ops[$];
    int acc_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rk_d[0] = rom[rk_idx[0]][{~rk_word[0], 5'b0} +: 32];
    assign rk_d[1] = rom[rk_idx[1]][{~rk_word[1], 5'b0} +: 32];

    aespim_enc_sequencer #(.NR(NR), .ST_LATENCY(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_v[0]), .req_ready_o(req_rdy[0]), .pt_i(pt_drv),
        .rsp_valid_o(rsp_v[0]), .rsp_ready_i(rsp_r[0]), .ct_o(ct[0]),
        .rk_idx_o(rk_idx[0]), .rk_word_o(rk_word[0]), .rk_data_i(rk_d[0]),
        .acc_start_o(start[0]), .acc_op_code_o(op[0]), .acc_data_o(acc_do[0]),
        .acc_data_i(acc_di[0]), .busy_o(busy[0])
    );

    aespim_enc_sequencer #(.NR(NR), .ST_LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_v[1]), .req_ready_o(req_rdy[1]), .pt_i(pt_drv),
        .rsp_valid_o(rsp_v[1]), .rsp_ready_i(rsp_r[1]), .ct_o(ct[1]),
        .rk_idx_o(rk_idx[1]), .rk_word_o(rk_word[1]), .rk_data_i(rk_d[1]),
        .acc_start_o(start[1]), .acc_op_code_o(op[1]), .acc_data_o(acc_do[1]),
        .acc_data_i(acc_di[1]), .busy_o(busy[1])
    );

    // ---------------- AES primitives ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] x0, x1, x2, x3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) a[n] = sbox[s[127-8*n -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
            if (fin) o[127-32*c -: 32] = {x0, x1, x2, x3};
            else o[127-32*c -: 32] = {gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3,
                                      x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3,
                                      x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03),
                                      gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02)};
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rom[0];
        for (int r = 1; r < NR; r++) s = aes_round(s, rom[r], 1'b0);
        return aes_round(s, rom[NR], 1'b1);
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rom[r] = '0;
        for (int r = 0; r <= NR; r++) rom[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [31:0] get_w(input logic [127:0] s, input logic [1:0] w);
        return s[{~w, 5'b0} +: 32];
    endfunction

    function automatic logic [127:0] put_w(input logic [127:0] s, input logic [1:0] w, input logic [31:0] v);
        s[{~w, 5'b0} +: 32] = v;
        return s;
    endfunction

    // ---------------- accelerator models ----------------
    logic [127:0] acc_st [2];
    logic [127:0] acc_k  [2];
    logic [1:0]   acc_lw [2];
    logic [1:0]   acc_fw [2];
    logic [1:0]   acc_sw [2];
    logic [31:0]  acc_pipe [2][3];

    assign acc_di[0] = acc_pipe[0][0];
    assign acc_di[1] = acc_pipe[1][2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                acc_st[i] <= '0; acc_k[i] <= '0;
                acc_lw[i] <= '0; acc_fw[i] <= '0; acc_sw[i] <= '0;
                for (int j = 0; j < 3; j++) acc_pipe[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc_pipe[i][1] <= acc_pipe[i][0];
                acc_pipe[i][2] <= acc_pipe[i][1];
                if (start[i]) begin
                    case (op[i][2:0])
                        3'b000: begin
                            acc_st[i] <= put_w(acc_st[i], acc_lw[i], acc_do[i]);
                            acc_lw[i] <= acc_lw[i] + 2'd1;
                        end
                        3'b100: acc_st[i] <= put_w(acc_st[i], op[i][4:3], get_w(acc_st[i], op[i][4:3]) ^ acc_do[i]);
                        3'b101: begin
                            if (op[i][4:3] == 2'd3) acc_st[i] <= aes_round(acc_st[i], put_w(acc_k[i], 2'd3, acc_do[i]), 1'b0);
                            else acc_k[i] <= put_w(acc_k[i], op[i][4:3], acc_do[i]);
                        end
                        3'b110: begin
                            if (acc_fw[i] == 2'd3) acc_st[i] <= aes_round(acc_st[i], put_w(acc_k[i], 2'd3, acc_do[i]), 1'b1);
                            else acc_k[i] <= put_w(acc_k[i], acc_fw[i], acc_do[i]);
                            acc_fw[i] <= acc_fw[i] + 2'd1;
                        end
                        3'b001: begin
                            acc_pipe[i][0] <= get_w(acc_st[i], acc_sw[i]);
                            acc_sw[i] <= acc_sw[i] + 2'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic op_t exp_op(input int j, input logic [127:0] pt);
        op_t e;
        logic [1:0] w;
        int ri;
        e = '0;
        w = 2'(j % 4);
        if (j < 4) begin
            e.op = 5'b00000;
            e.d  = pt[127-32*j -: 32];
        end else if (j < 8 + 4*NR) begin
            ri = (j - 4) / 4;
            e.op  = (ri == 0) ? {w, 3'b100} : (ri == NR) ? 5'b00110 : {w, 3'b101};
            e.idx = 4'(ri);
            e.wd  = w;
            e.d   = get_w(rom[ri], w);
        end else begin
            e.op = 5'b00001;
        end
        return e;
    endfunction

    task automatic run_req(input int inst, input logic [127:0] pt, output int rsp_cyc,
                           output int wait_cyc, output logic [127:0] ct_seen);
        int n;
        @(negedge clk);
        pt_drv = pt;
        req_v[inst] = 1'b1;
        wait_cyc = 0;
        while (!req_rdy[inst] && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        req_v[inst] = 1'b0;
        acc_cyc = cyc;
        ops.delete();
        rsp_cyc = -1;
        n = 1;
        while (n <= 200) begin
            if (start[inst]) ops.push_back({op[inst], rk_idx[inst], rk_word[inst], acc_do[inst]});
            if (rsp_v[inst]) begin
                rsp_cyc = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        ct_seen = ct[inst];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (req_rdy !== 2'b11) begin n_fail++; $display("FAIL rst_req_ready: got %b want 11", req_rdy); end
        n_cmp++; if (rsp_v !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_v); end
        n_cmp++; if (busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy: got %b want 00", busy); end
        n_cmp++; if (start !== 2'b00) begin n_fail++; $display("FAIL rst_acc_start: got %b want 00", start); end
        n_cmp++; if (ct[0] !== 128'h0) begin n_fail++; $display("FAIL rst_ct: got %h want 0", ct[0]); end
        n_cmp++; if (op[0] !== 5'h0) begin n_fail++; $display("FAIL rst_op_code: got %h want 0", op[0]); end
        n_cmp++; if (acc_do[0] !== 32'h0) begin n_fail++; $display("FAIL rst_acc_data: got %h want 0", acc_do[0]); end
        n_cmp++; if ({rk_idx[0], rk_word[0]} !== 6'h0) begin n_fail++; $display("FAIL rst_rk_sel: got %h want 0", {rk_idx[0], rk_word[0]}); end
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        logic [127:0] c;
        int rc, wc;
        op_t e, g;
        expand_key(FIPS_KEY);
        run_req(0, FIPS_PT, rc, wc, c);
        n_cmp++; if (rc != 54) begin n_fail++; $display("FAIL fips_rsp_cycle: got %0d want 54", rc); end
        n_cmp++; if (c !== FIPS_CT) begin n_fail++; $display("FAIL fips_ct: got %h want %h", c, FIPS_CT); end
        n_cmp++; if (c !== aes_ref(FIPS_PT)) begin n_fail++; $display("FAIL fips_ct_ref: got %h want %h", c, aes_ref(FIPS_PT)); end
        n_cmp++; if (ops.size() != 52) begin n_fail++; $display("FAIL op_count: got %0d want 52", ops.size()); end
        for (int j = 0; j < 52; j++) begin
            e = exp_op(j, FIPS_PT);
            g = (j < ops.size()) ? ops[j] : '1;
            if (e.op == 5'b00000 || e.op == 5'b00001) begin
                g.idx = '0;
                g.wd  = '0;
            end
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL op_stream[%0d]: got %h want %h", j, g, e); end
        end
    endtask

    task automatic test_latency3();
        logic [127:0] c;
        int rc, wc;
        expand_key(FIPS_KEY);
        run_req(1, FIPS_PT, rc, wc, c);
        n_cmp++; if (rc != 56) begin n_fail++; $display("FAIL lat3_rsp_cycle: got %0d want 56", rc); end
        n_cmp++; if (c !== FIPS_CT) begin n_fail++; $display("FAIL lat3_ct: got %h want %h", c, FIPS_CT); end
        n_cmp++; if (ops.size() != 52) begin n_fail++; $display("FAIL lat3_op_count: got %0d want 52", ops.size()); end
    endtask

    task automatic test_backpressure();
        logic [127:0] p1, p2, c1;
        int rc, wc, n;
        expand_key(FIPS_KEY);
        p1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        rsp_r[0] = 1'b0;
        run_req(0, p1, rc, wc, c1);
        n_cmp++; if (c1 !== aes_ref(p1)) begin n_fail++; $display("FAIL bp_ct: got %h want %h", c1, aes_ref(p1)); end
        pt_drv = p2;
        req_v[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ct[0] !== c1 || req_rdy[0] !== 1'b0 || start[0] !== 1'b0 || rsp_v[0] !== 1'b1 || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ct=%h rdy=%b start=%b rsp=%b busy=%b want ct=%h rdy=0 start=0 rsp=1 busy=1",
                         k, ct[0], req_rdy[0], start[0], rsp_v[0], busy[0], c1);
            end
        end
        rsp_r[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rsp_v[0], req_rdy[0], busy[0]} !== 3'b010) begin n_fail++; $display("FAIL bp_release: got rsp/rdy/busy=%b want 010", {rsp_v[0], req_rdy[0], busy[0]}); end
        n_cmp++; if (ct[0] !== c1) begin n_fail++; $display("FAIL bp_ct_kept: got %h want %h", ct[0], c1); end
        @(negedge clk);
        req_v[0] = 1'b0;
        n_cmp++; if ({busy[0], req_rdy[0], start[0]} !== 3'b101) begin n_fail++; $display("FAIL bp_next_accept: got busy/rdy/start=%b want 101", {busy[0], req_rdy[0], start[0]}); end
        n = 0;
        while (!rsp_v[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (ct[0] !== aes_ref(p2)) begin n_fail++; $display("FAIL bp_second_ct: got %h want %h", ct[0], aes_ref(p2)); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] c;
        int rc, wc, a1;
        for (int r = 0; r < 16; r++) rom[r] = '0;
        run_req(0, 128'h0, rc, wc, c);
        a1 = acc_cyc;
        n_cmp++; if (c !== aes_ref(128'h0)) begin n_fail++; $display("FAIL b2b_ct0: got %h want %h", c, aes_ref(128'h0)); end
        run_req(0, FIPS_PT, rc, wc, c);
        n_cmp++; if (c !== aes_ref(FIPS_PT)) begin n_fail++; $display("FAIL b2b_ct1: got %h want %h", c, aes_ref(FIPS_PT)); end
        n_cmp++; if (acc_cyc - a1 < 55) begin n_fail++; $display("FAIL b2b_spacing: got %0d want >=55", acc_cyc - a1); end
        n_cmp++; if (rc != 54) begin n_fail++; $display("FAIL b2b_rsp_cycle: got %0d want 54", rc); end
    endtask

    task automatic test_random();
        logic [127:0] c, p;
        int rc, wc, inst;
        for (int r = 0; r < 16; r++) rom[r] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            inst = k % 2;
            p = {$urandom, $urandom, $urandom, $urandom};
            run_req(inst, p, rc, wc, c);
            n_cmp++; if (c !== aes_ref(p)) begin n_fail++; $display("FAIL rand_ct[%0d]: got %h want %h", k, c, aes_ref(p)); end
            n_cmp++; if (rc != (inst == 1 ? 56 : 54)) begin n_fail++; $display("FAIL rand_rsp_cycle[%0d]: got %0d want %0d", k, rc, inst == 1 ? 56 : 54); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] c;
        int rc, wc;
        expand_key(FIPS_KEY);
        @(negedge clk);
        pt_drv = FIPS_PT;
        req_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        n_cmp++; if ({start[0], op[0]} !== 6'b1_11101) begin n_fail++; $display("FAIL mid_encm_op: got start/op=%b want 111101", {start[0], op[0]}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (req_rdy[0] !== 1'b1 || busy[0] !== 1'b0 || start[0] !== 1'b0 || op[0] !== 5'h0 ||
            acc_do[0] !== 32'h0 || rk_idx[0] !== 4'h0 || rk_word[0] !== 2'h0 || rsp_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b busy=%b start=%b op=%h data=%h idx=%h wd=%h rsp=%b want 1 0 0 0 0 0 0 0",
                     req_rdy[0], busy[0], start[0], op[0], acc_do[0], rk_idx[0], rk_word[0], rsp_v[0]);
        end
        n_cmp++; if (ct[0] !== 128'h0) begin n_fail++; $display("FAIL mid_reset_ct: got %h want 0", ct[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_req(0, FIPS_PT, rc, wc, c);
        n_cmp++; if (c !== FIPS_CT) begin n_fail++; $display("FAIL post_reset_ct: got %h want %h", c, FIPS_CT); end
        n_cmp++; if (rc != 54) begin n_fail++; $display("FAIL post_reset_rsp_cycle: got %0d want 54", rc); end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_v  = '0;
        rsp_r  = '1;
        pt_drv = '0;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int r = 0; r < 16; r++) rom[r] = '0;
        init_sbox();
        test_reset();
        test_fips();
        test_latency3();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
